// File: rtl/egress_tlp_arb.sv
// rtl/egress_tlp_arb.sv - packet arbiter sharing PCIe TX AXIS between cpl, rdreq and wrreq builders
// Define EGRESS_ARB_CPL_PRIO_EN to give completions strict priority over read/write requests.
module egress_tlp_arb #(
   parameter int DATA_W    = 128,
   parameter int KEEP_W    = 16,
   parameter int MAX_BEATS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] cpl_data,
   input  logic [KEEP_W-1:0] cpl_keep,
   input  logic              cpl_sop,
   input  logic              cpl_eop,
   input  logic              cpl_valid,
   output logic              cpl_rdy,
   input  logic [DATA_W-1:0] rdreq_data,
   input  logic [KEEP_W-1:0] rdreq_keep,
   input  logic              rdreq_sop,
   input  logic              rdreq_eop,
   input  logic              rdreq_valid,
   output logic              rdreq_rdy,
   input  logic [DATA_W-1:0] wrreq_data,
   input  logic [KEEP_W-1:0] wrreq_keep,
   input  logic              wrreq_sop,
   input  logic              wrreq_eop,
   input  logic              wrreq_valid,
   output logic              wrreq_rdy,
   output logic [DATA_W-1:0] m_axis_tx_tdata,
   output logic [KEEP_W-1:0] m_axis_tx_tkeep,
   output logic              m_axis_tx_sop,
   output logic              m_axis_tx_eop,
   output logic              m_axis_tx_tvalid,
   input  logic              m_axis_tx_tready,
   output logic [2:0]        grant,
   output logic              err_no_sop,
   output logic              err_overlen
);
   localparam int CNT_W = $clog2(MAX_BEATS) + 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t           state;
   logic [1:0]       rr_ptr;
   logic [CNT_W-1:0] beat_cnt;

   logic [2:0]        src_valid, src_sop, req, drop, pick;
   logic              out_free, acc, overlen;
   logic [1:0]        next_ptr;
   logic [DATA_W-1:0] sel_data;
   logic [KEEP_W-1:0] sel_keep;
   logic              sel_sop, sel_eop;

   // Bit order everywhere is {cpl, rdreq, wrreq}; rr_ptr 0/1/2 names cpl/rdreq/wrreq.
   assign src_valid = {cpl_valid, rdreq_valid, wrreq_valid};
   assign src_sop   = {cpl_sop, rdreq_sop, wrreq_sop};
   assign req       = src_valid & src_sop;
   assign out_free  = !m_axis_tx_tvalid || m_axis_tx_tready;
   assign drop      = (state == IDLE) ? (src_valid & ~src_sop) : 3'b000;
   assign acc       = |(grant & src_valid & {3{out_free}});
   assign cpl_rdy   = (grant[2] & out_free) | drop[2];
   assign rdreq_rdy = (grant[1] & out_free) | drop[1];
   assign wrreq_rdy = (grant[0] & out_free) | drop[0];
   assign overlen   = acc && !sel_eop && (beat_cnt == CNT_W'(MAX_BEATS - 1));
   assign next_ptr  = grant[2] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);

   always_comb begin
      sel_data = '0;
      sel_keep = '0;
      sel_sop  = 1'b0;
      sel_eop  = 1'b0;
      if (grant[2]) begin
         sel_data = cpl_data;   sel_keep = cpl_keep;   sel_sop = cpl_sop;   sel_eop = cpl_eop;
      end else if (grant[1]) begin
         sel_data = rdreq_data; sel_keep = rdreq_keep; sel_sop = rdreq_sop; sel_eop = rdreq_eop;
      end else if (grant[0]) begin
         sel_data = wrreq_data; sel_keep = wrreq_keep; sel_sop = wrreq_sop; sel_eop = wrreq_eop;
      end
   end

   always_comb begin
      pick = 3'b000;
`ifdef EGRESS_ARB_CPL_PRIO_EN
      if (req[2])              pick = 3'b100;
      else if (rr_ptr == 2'd2) pick = req[0] ? 3'b001 : (req[1] ? 3'b010 : 3'b000);
      else                     pick = req[1] ? 3'b010 : (req[0] ? 3'b001 : 3'b000);
`else
      case (rr_ptr)
         2'd0:    pick = req[2] ? 3'b100 : (req[1] ? 3'b010 : (req[0] ? 3'b001 : 3'b000));
         2'd1:    pick = req[1] ? 3'b010 : (req[0] ? 3'b001 : (req[2] ? 3'b100 : 3'b000));
         default: pick = req[0] ? 3'b001 : (req[2] ? 3'b100 : (req[1] ? 3'b010 : 3'b000));
      endcase
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         rr_ptr           <= 2'd0;
         beat_cnt         <= '0;
         grant            <= 3'b000;
         err_no_sop       <= 1'b0;
         err_overlen      <= 1'b0;
         m_axis_tx_tdata  <= '0;
         m_axis_tx_tkeep  <= '0;
         m_axis_tx_sop    <= 1'b0;
         m_axis_tx_eop    <= 1'b0;
         m_axis_tx_tvalid <= 1'b0;
      end else begin
         if (|drop) err_no_sop <= 1'b1;

         if (acc) begin
            m_axis_tx_tdata  <= sel_data;
            m_axis_tx_tkeep  <= sel_keep;
            m_axis_tx_sop    <= sel_sop;
            m_axis_tx_eop    <= sel_eop | overlen;
            m_axis_tx_tvalid <= 1'b1;
         end else if (m_axis_tx_tready) begin
            m_axis_tx_tvalid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (|pick) begin
                  grant    <= pick;
                  beat_cnt <= '0;
                  state    <= XFER;
               end
            end
            default: begin
               // An overlength packet is cut like a normal eop; its tail then arrives headless.
               if (acc) begin
                  if (sel_eop || overlen) begin
                     grant    <= 3'b000;
                     beat_cnt <= '0;
                     rr_ptr   <= next_ptr;
                     state    <= IDLE;
                     if (overlen) err_overlen <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_egress_tlp_arb.sv
// tb/tb_egress_tlp_arb.sv - self-checking bench for egress_tlp_arb with a packet-level reference model
module tb_egress_tlp_arb;
   localparam int DW = 128, KW = 16, MAXB = 4;
`ifdef EGRESS_ARB_CPL_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          sop;
      logic          eop;
   } beat_t;
   typedef struct { int cyc; beat_t b; } obs_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [DW-1:0] cpl_data, rdreq_data, wrreq_data, m_axis_tx_tdata;
   logic [KW-1:0] cpl_keep, rdreq_keep, wrreq_keep, m_axis_tx_tkeep;
   logic cpl_sop, cpl_eop, cpl_valid, cpl_rdy;
   logic rdreq_sop, rdreq_eop, rdreq_valid, rdreq_rdy;
   logic wrreq_sop, wrreq_eop, wrreq_valid, wrreq_rdy;
   logic m_axis_tx_sop, m_axis_tx_eop, m_axis_tx_tvalid, m_axis_tx_tready;
   logic [2:0] grant;
   logic err_no_sop, err_overlen;

   always #5 clk = ~clk;

   egress_tlp_arb #(.DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst(rst),
      .cpl_data(cpl_data), .cpl_keep(cpl_keep), .cpl_sop(cpl_sop), .cpl_eop(cpl_eop),
      .cpl_valid(cpl_valid), .cpl_rdy(cpl_rdy),
      .rdreq_data(rdreq_data), .rdreq_keep(rdreq_keep), .rdreq_sop(rdreq_sop), .rdreq_eop(rdreq_eop),
      .rdreq_valid(rdreq_valid), .rdreq_rdy(rdreq_rdy),
      .wrreq_data(wrreq_data), .wrreq_keep(wrreq_keep), .wrreq_sop(wrreq_sop), .wrreq_eop(wrreq_eop),
      .wrreq_valid(wrreq_valid), .wrreq_rdy(wrreq_rdy),
      .m_axis_tx_tdata(m_axis_tx_tdata), .m_axis_tx_tkeep(m_axis_tx_tkeep),
      .m_axis_tx_sop(m_axis_tx_sop), .m_axis_tx_eop(m_axis_tx_eop),
      .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tready(m_axis_tx_tready),
      .grant(grant), .err_no_sop(err_no_sop), .err_overlen(err_overlen)
   );

   int checks = 0, passed = 0, cyc = 0, pkt_tag = 0;
   beat_t q_cpl[$], q_rd[$], q_wr[$];
   beat_t cur [3];
   bit    pres [3];
   bit    took [3];
   bit    gaps = 1'b0, rand_ready = 1'b0;
   int    stall_start = -1, stall_len = 0;
   obs_t  out_log[$];
   logic [2:0]    grant_log [0:63];
   logic [2:0]    rdy_log   [0:63];
   logic [DW-1:0] tdata_log [0:63];
   logic          nosop_log [0:63];

   // Reference model: bus owner (-1 = none), next-in-turn source, beats in the current packet,
   // sticky errors and the beat sitting in the output register.
   int    m_owner, m_ptr, m_cnt;
   bit    m_err_nosop, m_err_ovl;
   beat_t exp_q[$];

   function automatic int qsize(int s);
      if (s == 0) return q_cpl.size();
      if (s == 1) return q_rd.size();
      return q_wr.size();
   endfunction

   task automatic qpush(int s, beat_t b);
      if (s == 0) q_cpl.push_back(b);
      else if (s == 1) q_rd.push_back(b);
      else q_wr.push_back(b);
   endtask

   task automatic qpop(int s, output beat_t b);
      if (s == 0) b = q_cpl.pop_front();
      else if (s == 1) b = q_rd.pop_front();
      else b = q_wr.pop_front();
   endtask

   task automatic add_pkt(int s, int len, bit first_sop);
      beat_t b;
      logic [7:0] sid, tag;
      logic [15:0] idx;
      sid = 8'(s);
      tag = 8'(pkt_tag);
      pkt_tag++;
      for (int i = 0; i < len; i++) begin
         idx    = 16'(i);
         b.data = {sid, tag, idx, $urandom(), $urandom(), $urandom()};
         b.keep = 16'($urandom());
         b.sop  = (i == 0) && first_sop;
         b.eop  = (i == len - 1);
         qpush(s, b);
      end
   endtask

   task automatic drive_inputs();
      for (int s = 0; s < 3; s++)
         if (!pres[s] && qsize(s) > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            qpop(s, cur[s]);
            pres[s] = 1'b1;
         end
      cpl_valid   = pres[0]; cpl_data   = cur[0].data; cpl_keep   = cur[0].keep;
      cpl_sop     = cur[0].sop; cpl_eop = cur[0].eop;
      rdreq_valid = pres[1]; rdreq_data = cur[1].data; rdreq_keep = cur[1].keep;
      rdreq_sop   = cur[1].sop; rdreq_eop = cur[1].eop;
      wrreq_valid = pres[2]; wrreq_data = cur[2].data; wrreq_keep = cur[2].keep;
      wrreq_sop   = cur[2].sop; wrreq_eop = cur[2].eop;
      if (rand_ready) m_axis_tx_tready = ($urandom_range(0, 3) != 0);
      else m_axis_tx_tready = !(cyc >= stall_start && cyc < stall_start + stall_len);
   endtask

   task automatic model_step();
      bit free;
      int win, c;
      beat_t b, ob;
      logic [2:0] dut_rdy, exp_g;
      dut_rdy = {cpl_rdy, rdreq_rdy, wrreq_rdy};
      ob      = {m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_sop, m_axis_tx_eop};
      free    = (exp_q.size() == 0) || (m_axis_tx_tready == 1'b1);
      for (int s = 0; s < 3; s++) begin
         took[s] = (m_owner == s && free) || (m_owner < 0 && pres[s] && !cur[s].sop);
         checks++;
         if (dut_rdy[2-s] !== took[s])
            $display("FAIL rdy src%0d cyc%0d: got %b expected %b", s, cyc, dut_rdy[2-s], took[s]);
         else passed++;
      end
      exp_g = (m_owner < 0) ? 3'b000 : (3'b100 >> m_owner);
      checks++;
      if (grant !== exp_g) $display("FAIL grant cyc%0d: got %b expected %b", cyc, grant, exp_g);
      else passed++;
      checks++;
      if (m_axis_tx_tvalid !== (exp_q.size() != 0))
         $display("FAIL tvalid cyc%0d: got %b expected %b", cyc, m_axis_tx_tvalid, exp_q.size() != 0);
      else passed++;
      if (m_axis_tx_tvalid === 1'b1 && exp_q.size() != 0) begin
         checks++;
         if (ob !== exp_q[0]) $display("FAIL out_beat cyc%0d: got %h expected %h", cyc, ob, exp_q[0]);
         else passed++;
      end
      checks++;
      if ({err_no_sop, err_overlen} !== {m_err_nosop, m_err_ovl})
         $display("FAIL err_flags cyc%0d: got %b%b expected %b%b", cyc, err_no_sop, err_overlen,
                  m_err_nosop, m_err_ovl);
      else passed++;

      if (exp_q.size() != 0 && m_axis_tx_tready) void'(exp_q.pop_front());
      if (m_owner < 0) begin
         for (int s = 0; s < 3; s++) if (took[s]) m_err_nosop = 1'b1;
         win = -1;
         if (PRIO && pres[0] && cur[0].sop) win = 0;
         for (int k = 0; k < 3; k++) begin
            c = (m_ptr + k) % 3;
            if (win < 0 && !(PRIO && c == 0) && pres[c] && cur[c].sop) win = c;
         end
         if (win >= 0) begin
            m_owner = win;
            m_cnt   = 0;
         end
      end else if (pres[m_owner] && took[m_owner]) begin
         b = cur[m_owner];
         if (!b.eop && m_cnt == MAXB - 1) begin
            b.eop     = 1'b1;
            m_err_ovl = 1'b1;
         end
         exp_q.push_back(b);
         if (b.eop) begin
            m_ptr   = (m_owner + 1) % 3;
            m_owner = -1;
         end else m_cnt++;
      end
   endtask

   task automatic run_cycles(int n);
      beat_t ob;
      for (int i = 0; i < n; i++) begin
         drive_inputs();
         #1;
         if (cyc < 64) begin
            grant_log[cyc] = grant;
            rdy_log[cyc]   = {cpl_rdy, rdreq_rdy, wrreq_rdy};
            tdata_log[cyc] = m_axis_tx_tdata;
            nosop_log[cyc] = err_no_sop;
         end
         if (m_axis_tx_tvalid && m_axis_tx_tready) begin
            ob = {m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_sop, m_axis_tx_eop};
            out_log.push_back('{cyc, ob});
         end
         model_step();
         for (int s = 0; s < 3; s++) if (pres[s] && took[s]) pres[s] = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q_cpl.delete(); q_rd.delete(); q_wr.delete();
      for (int s = 0; s < 3; s++) begin
         pres[s] = 1'b0;
         cur[s]  = '0;
      end
      cpl_valid = 1'b0; rdreq_valid = 1'b0; wrreq_valid = 1'b0;
      cpl_sop = 1'b0; rdreq_sop = 1'b0; wrreq_sop = 1'b0;
      m_axis_tx_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_owner = -1; m_ptr = 0; m_cnt = 0;
      m_err_nosop = 1'b0; m_err_ovl = 1'b0;
      exp_q.delete(); out_log.delete();
      cyc = 0; gaps = 1'b0; rand_ready = 1'b0; stall_start = -1; stall_len = 0;
   endtask

   function automatic bit all_idle();
      return qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0 && !pres[0] && !pres[1] && !pres[2]
             && exp_q.size() == 0 && m_owner < 0;
   endfunction

   task automatic test_reset();
      add_pkt(0, 4, 1'b1);
      run_cycles(3);
      do_reset();
      checks++;
      if ({m_axis_tx_tvalid, grant} !== 4'b0000)
         $display("FAIL reset_mid_pkt: got tvalid=%b grant=%b expected 0/000", m_axis_tx_tvalid, grant);
      else passed++;
      checks++;
      if ({m_axis_tx_sop, m_axis_tx_eop, m_axis_tx_tdata} !== '0)
         $display("FAIL reset_out_regs: got sop=%b eop=%b data=%h expected 0", m_axis_tx_sop,
                  m_axis_tx_eop, m_axis_tx_tdata);
      else passed++;
      checks++;
      if ({cpl_rdy, rdreq_rdy, wrreq_rdy, err_no_sop, err_overlen} !== 5'b0)
         $display("FAIL reset_rdy_err: got %b expected 00000",
                  {cpl_rdy, rdreq_rdy, wrreq_rdy, err_no_sop, err_overlen});
      else passed++;
   endtask

   task automatic test_single_wrreq();
      beat_t sent[$];
      do_reset();
      add_pkt(2, 3, 1'b1);
      sent = q_wr;
      run_cycles(8);
      checks++;
      if (out_log.size() != 3) $display("FAIL single_count: got %0d expected 3", out_log.size());
      else passed++;
      for (int i = 0; i < 3 && i < out_log.size(); i++) begin
         checks++;
         if (out_log[i].cyc != 2 + i)
            $display("FAIL single_timing[%0d]: got cycle %0d expected %0d", i, out_log[i].cyc, 2 + i);
         else passed++;
         checks++;
         if (out_log[i].b !== sent[i])
            $display("FAIL single_beat[%0d]: got %h expected %h", i, out_log[i].b, sent[i]);
         else passed++;
      end
      checks++;
      if ({grant_log[1], grant_log[3], grant_log[4]} !== 9'b001_001_000)
         $display("FAIL single_grant: got %b/%b/%b expected 001/001/000", grant_log[1], grant_log[3],
                  grant_log[4]);
      else passed++;
   endtask

   task automatic test_round_robin();
      int exp_c[5];
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 3; s++) add_pkt(s, 1, 1'b1);
         run_cycles(8);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_log.size() <= i) $display("FAIL rr_order[%0d]: got nothing expected src%0d", i, i % 3);
         else if (out_log[i].b.data[127:120] != 8'(i % 3))
            $display("FAIL rr_order[%0d]: got src%0d expected src%0d", i, out_log[i].b.data[127:120], i % 3);
         else passed++;
      end
      for (int i = 0; i < 3 && i < out_log.size(); i++) begin
         checks++;
         if (out_log[i].cyc != 2 + 2 * i)
            $display("FAIL rr_timing[%0d]: got cycle %0d expected %0d", i, out_log[i].cyc, 2 + 2 * i);
         else passed++;
      end
      if (PRIO) exp_c = '{0, 0, 0, 1, 2};
      else exp_c = '{0, 1, 2, 0, 0};
      for (int p = 0; p < 3; p++) add_pkt(0, 1, 1'b1);
      add_pkt(1, 1, 1'b1);
      add_pkt(2, 1, 1'b1);
      run_cycles(14);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_log.size() <= 6 + i) $display("FAIL cpl_burst[%0d]: got nothing expected src%0d", i, exp_c[i]);
         else if (out_log[6+i].b.data[127:120] != 8'(exp_c[i]))
            $display("FAIL cpl_burst[%0d]: got src%0d expected src%0d", i, out_log[6+i].b.data[127:120], exp_c[i]);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      beat_t sent[$];
      int exp_cyc[4] = '{2, 6, 7, 8};
      do_reset();
      add_pkt(1, 4, 1'b1);
      sent = q_rd;
      stall_start = 3;
      stall_len   = 3;
      run_cycles(12);
      checks++;
      if (out_log.size() != 4) $display("FAIL bp_count: got %0d expected 4", out_log.size());
      else passed++;
      for (int i = 0; i < 4 && i < out_log.size(); i++) begin
         checks++;
         if (out_log[i].cyc != exp_cyc[i] || out_log[i].b !== sent[i])
            $display("FAIL bp_beat[%0d]: got cycle %0d data %h expected cycle %0d data %h", i,
                     out_log[i].cyc, out_log[i].b.data, exp_cyc[i], sent[i].data);
         else passed++;
      end
      for (int c = 3; c < 6; c++) begin
         checks++;
         if (tdata_log[c] !== sent[1].data || rdy_log[c] !== 3'b000)
            $display("FAIL bp_hold cyc%0d: got data %h rdy %b expected %h rdy 000", c, tdata_log[c],
                     rdy_log[c], sent[1].data);
         else passed++;
      end
   endtask

   task automatic test_no_sop();
      do_reset();
      add_pkt(2, 1, 1'b0);
      run_cycles(4);
      checks++;
      if (rdy_log[0] !== 3'b001) $display("FAIL nosop_rdy: got %b expected 001", rdy_log[0]);
      else passed++;
      checks++;
      if ({nosop_log[1], nosop_log[3]} !== 2'b11 || out_log.size() != 0)
         $display("FAIL nosop_sticky: got %b%b beats=%0d expected 11 beats=0", nosop_log[1],
                  nosop_log[3], out_log.size());
      else passed++;
      do_reset();
      checks++;
      if (err_no_sop !== 1'b0) $display("FAIL nosop_clear: got %b expected 0", err_no_sop);
      else passed++;
   endtask

   task automatic test_overlen();
      do_reset();
      add_pkt(0, 6, 1'b1);
      run_cycles(10);
      checks++;
      if (out_log.size() != 4) $display("FAIL ovl_count: got %0d expected 4", out_log.size());
      else passed++;
      if (out_log.size() == 4) begin
         checks++;
         if ({out_log[2].b.eop, out_log[3].b.eop, out_log[3].cyc} !== {2'b01, 32'(5)})
            $display("FAIL ovl_eop: got eop2=%b eop3=%b cycle %0d expected 0/1/5", out_log[2].b.eop,
                     out_log[3].b.eop, out_log[3].cyc);
         else passed++;
      end
      checks++;
      if ({err_overlen, err_no_sop, grant_log[5], rdy_log[5]} !== 8'b11_000_100)
         $display("FAIL ovl_flags: got ovl=%b nosop=%b grant=%b rdy=%b expected 1/1/000/100",
                  err_overlen, err_no_sop, grant_log[5], rdy_log[5]);
      else passed++;
      checks++;
      if (qsize(0) != 0 || pres[0]) $display("FAIL ovl_tail_drop: got %0d beats left expected 0", qsize(0) + pres[0]);
      else passed++;
   endtask

   task automatic test_random();
      int len;
      do_reset();
      for (int p = 0; p < 300; p++) begin
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 6) : $urandom_range(1, 4);
         add_pkt($urandom_range(0, 2), len, 1'b1);
      end
      gaps       = 1'b1;
      rand_ready = 1'b1;
      run_cycles(1500);
      gaps       = 1'b0;
      rand_ready = 1'b0;
      for (int i = 0; i < 4000 && !all_idle(); i++) run_cycles(1);
      checks++;
      if (!all_idle()) $display("FAIL random_drain: got %0d beats outstanding expected 0",
                                qsize(0) + qsize(1) + qsize(2) + exp_q.size());
      else passed++;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      test_reset();
      test_single_wrreq();
      test_round_robin();
      test_backpressure();
      test_no_sop();
      test_overlen();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/egress_tlp_arb.md
Name: egress_tlp_arb

Overview:
- Packet-level arbiter that shares the single PCIe TX AXIS interface between three TLP sources: completion (cpl), read request (rdreq) and write request (wrreq).
- Sits at the egress side, mirroring the ingress three-way split; its sources are the cpl/rdreq/wrreq builders.
- Grants whole TLPs (sop..eop) without interleaving, using round-robin order, and drives a registered output stage.

Parameters:
- DATA_W, 128, TLP data width; equals `PCIE_DATA_WIDTH.
- KEEP_W, 16, byte-enable width; equals `PCIE_DATA_KW.
- MAX_BEATS, 64, packet length guard in beats; a grant is aborted once this count is reached.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpl_data / rdreq_data / wrreq_data  in  DATA_W each  source beat data
- cpl_keep / rdreq_keep / wrreq_keep  in  KEEP_W each  source byte enables
- cpl_sop/eop, rdreq_sop/eop, wrreq_sop/eop  in  1 each  packet delimiters
- cpl_valid / rdreq_valid / wrreq_valid  in  1 each  source beat valid
- cpl_rdy / rdreq_rdy / wrreq_rdy  out  1 each  source ready
- m_axis_tx_tdata  out  DATA_W  TX data
- m_axis_tx_tkeep  out  KEEP_W  TX byte enables
- m_axis_tx_sop / m_axis_tx_eop  out  1  TX delimiters
- m_axis_tx_tvalid  out  1  TX valid
- m_axis_tx_tready  in  1  TX ready
- grant  out  3  one-hot current owner {cpl,rdreq,wrreq}; 0 when idle
- err_no_sop  out  1  sticky: a beat arrived without sop while its source held no grant
- err_overlen  out  1  sticky: packet reached MAX_BEATS without eop

Behaviour:
- Single clock domain on clk. rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer selects cpl first, beat counter 0.
- Source handshake: beat accepted when x_valid && x_rdy.
- Output handshake: beat leaves when m_axis_tx_tvalid && m_axis_tx_tready.
- Output stage is one register. Data/keep/sop/eop/valid are loaded on every accepted source beat.
- Output clear: tvalid clears when the register drains and no new beat is accepted.
- x_rdy = grant[x] && (!m_axis_tx_tvalid || m_axis_tx_tready). This allows full throughput with 1-cycle latency. Ready is combinational from tready.
- FSM IDLE:
  - Requesters are sources with valid && sop.
  - Pick the first requester at or after the RR pointer, in order cpl -> rdreq -> wrreq -> cpl.
  - grant becomes one-hot on the next cycle; state goes to XFER.
  - No beats are accepted in IDLE, so there is 1 arbitration cycle per packet.
- FSM XFER:
  - Forward the granted source only.
  - The beat counter increments per accepted beat.
  - On an accepted beat with eop=1:
    - grant clears and counter resets.
    - RR pointer moves to the source after the winner.
    - Return to IDLE.
  - A single-beat packet (sop=eop=1) occupies exactly one XFER cycle when tready=1.
- Overlength: if the counter reaches MAX_BEATS-1 on an accepted beat without eop:
  - Force m_axis_tx_eop=1 on that beat and set err_overlen.
  - Release the grant; the source's remaining beats hit the no-sop rule.
- No-sop beats: in IDLE, a valid beat with sop=0 from any source is dropped. That source's rdy is forced to 1 for that cycle and err_no_sop is set.
  - Precedence: no-sop dropping applies only to sources not being granted that cycle.
- Backpressure: if tready=0 while tvalid=1, output registers hold and all x_rdy=0.
- Reset mid-packet: the partial packet is discarded and the output returns to idle. No eop is emitted.
- Simultaneous requests: only one grant. Losers keep valid asserted; the protocol requires data stable while waiting.

Optional Feature:
- Macro: EGRESS_ARB_CPL_PRIO_EN.
- Defined: in IDLE, a cpl requester always wins over rdreq and wrreq (strict priority). rdreq and wrreq round-robin between themselves. This prevents completion starvation behind posted writes.
- Undefined: pure 3-way round-robin as described above.

Test Plan:
- Single source, wrreq 3-beat TLP, tready=1:
  - Beats appear at m_axis_tx 2 cycles after first valid, on consecutive cycles.
  - sop on beat 0, eop on beat 2; grant=3'b001 during transfer.
- All three assert a 1-beat TLP from reset, macro off:
  - Output order cpl, rdreq, wrreq; 2 cycles per packet.
  - Repeating the stimulus yields the same order again.
- Same stimulus with EGRESS_ARB_CPL_PRIO_EN, cpl resubmitting continuously:
  - cpl wins every arbitration; rdreq/wrreq are served only when cpl_valid is 0.
- 4-beat rdreq with tready low for 3 cycles after beat 1:
  - Beat 1 is held stable and no beat is lost or duplicated; output shows 4 beats total.
- wrreq_valid=1 with sop=0 in IDLE:
  - wrreq_rdy=1 that cycle, the beat is dropped and err_no_sop=1 until reset.
  - With MAX_BEATS=4 and a 6-beat packet, output eop is forced on beat 3 and err_overlen=1.
